// File: rtl/intr_pkg.sv
// Shared types and helpers for the interrupt/trap controller.
package intr_pkg;

  typedef enum logic [2:0] {IDLE, REQ, SVC, TREQ, TSVC} state_t;

  localparam int MAX_IRQ = 16;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } prio_t;

  // The trap always takes the vector just above the last maskable channel.
  function automatic int trap_vec(input int n_irq);
    return n_irq;
  endfunction

  function automatic prio_t prio_enc(input logic [MAX_IRQ-1:0] req);
    prio_t r;
    r.valid = 1'b0;
    r.idx   = '0;
    for (int i = MAX_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        r.valid = 1'b1;
        r.idx   = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/intr_sync_edge.sv
// Synchroniser for one asynchronous line followed by a registered rising-edge
// pulse (EDGE=1) or a registered copy of the synchronised level (EDGE=0).
module intr_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE        = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic det
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   det_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_reg <= '0;
    else          sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
  end

  generate
    if (EDGE) begin : g_edge
      logic dly_reg;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          dly_reg <= 1'b0;
          det_reg <= 1'b0;
        end else begin
          dly_reg <= sync_reg[SYNC_STAGES-1];
          det_reg <= sync_reg[SYNC_STAGES-1] & ~dly_reg;
        end
      end
    end else begin : g_level
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) det_reg <= 1'b0;
        else          det_reg <= sync_reg[SYNC_STAGES-1];
      end
    end
  endgenerate

  assign det = det_reg;

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt/trap controller: synchronises N_IRQ maskable lines plus a trap,
// latches pending bits and hands one vector at a time to the CPU.
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int                N_IRQ       = 8,
  parameter int                VEC_W       = $clog2(N_IRQ + 1),
  parameter logic [N_IRQ-1:0]  EDGE_MODE   = {N_IRQ{1'b1}},
  parameter int                SYNC_STAGES = 2,
  parameter logic [N_IRQ-1:0]  MASK_RST    = {N_IRQ{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             trap_in,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  output logic [N_IRQ-1:0] mask_q,
  output logic [N_IRQ-1:0] pending_q,
  output logic             irq_req,
  output logic [VEC_W-1:0] irq_vec,
  input  logic             irq_ack,
  input  logic             eoi,
  output logic             in_service,
  output logic             in_trap
);

  localparam logic [N_IRQ:0]   EDGE_ALL = {1'b1, EDGE_MODE};
  localparam logic [VEC_W-1:0] TRAP_VEC = VEC_W'(trap_vec(N_IRQ));

  logic [N_IRQ:0]   raw;
  logic [N_IRQ:0]   det;
  state_t           state_reg, state_next;
  logic             ret_svc_reg, ret_svc_next;
  logic [VEC_W-1:0] vec_reg, vec_next;
  logic [N_IRQ-1:0] pending_reg, pending_next;
  logic [N_IRQ-1:0] mask_reg;
  logic [N_IRQ-1:0] clr_edge;
  logic             trap_pend_reg, trap_pend_next, trap_clr;
  prio_t            win;

  assign raw = {trap_in, irq_in};

  // Channel N_IRQ is the trap line, always edge-detected.
  genvar gi;
  generate
    for (gi = 0; gi <= N_IRQ; gi++) begin : g_sync
      intr_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES),
        .EDGE       (EDGE_ALL[gi])
      ) u_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .din    (raw[gi]),
        .det    (det[gi])
      );
    end
  endgenerate

  assign win = prio_enc(MAX_IRQ'(pending_reg & mask_reg));

  always_comb begin
    state_next   = state_reg;
    ret_svc_next = ret_svc_reg;
    vec_next     = vec_reg;
    clr_edge     = '0;
    trap_clr     = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (trap_pend_reg) begin
          state_next   = TREQ;
          vec_next     = TRAP_VEC;
          ret_svc_next = 1'b0;
        end else if (win.valid) begin
          state_next = REQ;
          vec_next   = VEC_W'(win.idx);
        end
      end
      REQ: begin
        if (irq_ack) begin
          state_next = SVC;
          clr_edge   = EDGE_MODE & (N_IRQ'(1) << vec_reg);
        end
      end
      SVC: begin
        if (eoi) begin
          state_next = IDLE;
        end else if (trap_pend_reg) begin
          state_next   = TREQ;
          vec_next     = TRAP_VEC;
          ret_svc_next = 1'b1;
        end
      end
      TREQ: begin
        if (irq_ack) begin
          state_next = TSVC;
          trap_clr   = 1'b1;
        end
      end
      TSVC: begin
        if (eoi) state_next = ret_svc_reg ? SVC : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A fresh edge in the same cycle as the ack-clear keeps the bit set.
  assign pending_next   = (EDGE_MODE & ((pending_reg & ~clr_edge) | det[N_IRQ-1:0]))
                        | (~EDGE_MODE & det[N_IRQ-1:0]);
  assign trap_pend_next = (trap_pend_reg & ~trap_clr) | det[N_IRQ];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      ret_svc_reg   <= 1'b0;
      vec_reg       <= '0;
      pending_reg   <= '0;
      trap_pend_reg <= 1'b0;
      mask_reg      <= MASK_RST;
    end else begin
      state_reg     <= state_next;
      ret_svc_reg   <= ret_svc_next;
      vec_reg       <= vec_next;
      pending_reg   <= pending_next;
      trap_pend_reg <= trap_pend_next;
      if (mask_we) mask_reg <= mask_wdata;
    end
  end

  assign mask_q     = mask_reg;
  assign pending_q  = pending_reg;
  assign irq_vec    = vec_reg;
  assign irq_req    = (state_reg == REQ) || (state_reg == TREQ);
  assign in_service = (state_reg == SVC);
  assign in_trap    = (state_reg == TSVC);

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed scenarios plus random traffic, checked every cycle against a
// handler-stack reference model of the controller.
module tb_intr_ctrl;

  localparam int            N  = 8;
  localparam int            VW = $clog2(N + 1);
  localparam logic [N-1:0]  EM = 8'hFE;
  localparam logic [N-1:0]  MR = 8'hFF;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  irq_in = '0;
  logic          trap_in = 1'b0;
  logic          mask_we = 1'b0;
  logic [N-1:0]  mask_wdata = '0;
  logic          irq_ack = 1'b0;
  logic          eoi = 1'b0;
  logic [N-1:0]  mask_q, pending_q;
  logic          irq_req, in_service, in_trap;
  logic [VW-1:0] irq_vec;

  always #5 clk = ~clk;

  intr_ctrl #(
    .N_IRQ(N), .VEC_W(VW), .EDGE_MODE(EM), .SYNC_STAGES(2), .MASK_RST(MR)
  ) dut (
    .clk(clk), .reset_n(reset_n), .irq_in(irq_in), .trap_in(trap_in),
    .mask_we(mask_we), .mask_wdata(mask_wdata), .mask_q(mask_q),
    .pending_q(pending_q), .irq_req(irq_req), .irq_vec(irq_vec),
    .irq_ack(irq_ack), .eoi(eoi), .in_service(in_service), .in_trap(in_trap)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: raw sample history, pending/mask/trap bits, the vector
  // currently offered (-1 = none) and a stack of active handlers.
  logic [N:0]   hist [4];
  logic [N-1:0] m_pend, m_mask;
  logic         m_tp;
  int           m_req;
  int           m_stack[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) hist[i] = '0;
    m_pend = '0;
    m_mask = MR;
    m_tp   = 1'b0;
    m_req  = -1;
    m_stack.delete();
  endtask

  task automatic model_step();
    logic [N-1:0] rise, lvl, clr, avail;
    logic         t_rise, t_clr;
    int           nreq;
    rise   = hist[2][N-1:0] & ~hist[3][N-1:0];
    lvl    = hist[2][N-1:0];
    t_rise = hist[2][N] & ~hist[3][N];
    clr    = '0;
    t_clr  = 1'b0;
    nreq   = m_req;
    avail  = m_pend & m_mask;
    if (m_req >= 0 && irq_ack) begin
      if (m_req == N) t_clr = 1'b1;
      else            clr[m_req] = 1'b1;
      m_stack.push_back(m_req);
      nreq = -1;
    end else if (m_req < 0 && m_stack.size() > 0 && eoi) begin
      void'(m_stack.pop_back());
    end else if (m_req < 0 && (m_stack.size() == 0 || m_stack[$] != N)) begin
      if (m_tp) nreq = N;
      else if (m_stack.size() == 0 && avail != '0)
        for (int i = N - 1; i >= 0; i--) if (avail[i]) nreq = i;
    end
    for (int i = 0; i < N; i++)
      m_pend[i] = EM[i] ? ((m_pend[i] & ~clr[i]) | rise[i]) : lvl[i];
    m_tp = (m_tp & ~t_clr) | t_rise;
    if (mask_we) m_mask = mask_wdata;
    m_req = nreq;
    hist[3] = hist[2];
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = {trap_in, irq_in};
  endtask

  task automatic compare();
    check("irq_req", 32'(irq_req), 32'(m_req >= 0));
    if (m_req >= 0) check("irq_vec", 32'(irq_vec), 32'(m_req));
    check("in_service", 32'(in_service),
          32'(m_req < 0 && m_stack.size() > 0 && m_stack[$] != N));
    check("in_trap", 32'(in_trap), 32'(m_stack.size() > 0 && m_stack[$] == N));
    check("pending_q", 32'(pending_q), 32'(m_pend));
    check("mask_q", 32'(mask_q), 32'(m_mask));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!irq_req && n < 20) begin
      cycle();
      n++;
    end
    check({tag, "_req"}, 32'(irq_req), 32'd1);
  endtask

  task automatic do_ack();
    irq_ack = 1'b1;
    cycle();
    irq_ack = 1'b0;
  endtask

  task automatic do_eoi();
    eoi = 1'b1;
    cycle();
    eoi = 1'b0;
  endtask

  task automatic pulse_irq(input int ch);
    irq_in[ch] = 1'b1;
    repeat (2) cycle();
    irq_in[ch] = 1'b0;
  endtask

  task automatic write_mask(input logic [N-1:0] m);
    mask_we    = 1'b1;
    mask_wdata = m;
    cycle();
    mask_we    = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check("rst_req", 32'(irq_req), 32'd0);
    check("rst_vec", 32'(irq_vec), 32'd0);
    check("rst_mask", 32'(mask_q), 32'(MR));
    check("rst_pend", 32'(pending_q), 32'd0);
    check("rst_svc", 32'({in_service, in_trap}), 32'd0);

    // Single edge on channel 3, left unacknowledged for a while.
    irq_in[3] = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      cycle();
      if (c == 2) irq_in[3] = 1'b0;
      check("s1_latency", 32'(irq_req), 32'(c == 5));
    end
    check("s1_vec", 32'(irq_vec), 32'd3);
    repeat (10) begin
      cycle();
      check("s1_hold", 32'(irq_vec), 32'd3);
    end
    do_ack();
    check("s1_pend3", 32'(pending_q[3]), 32'd0);
    check("s1_insvc", 32'(in_service), 32'd1);
    do_eoi();
    check("s1_eoi", 32'(in_service), 32'd0);
    repeat (5) cycle();
    check("s1_quiet", 32'(irq_req), 32'd0);
    $display("scenario single_edge done");

    // Two channels rising together: lower index first.
    irq_in = 8'h24;
    repeat (2) cycle();
    irq_in = '0;
    wait_req("s2a");
    check("s2_vec2", 32'(irq_vec), 32'd2);
    do_ack();
    do_eoi();
    check("s2_idle", 32'(irq_req), 32'd0);
    cycle();
    check("s2_req5", 32'(irq_req), 32'd1);
    check("s2_vec5", 32'(irq_vec), 32'd5);
    do_ack();
    do_eoi();
    $display("scenario priority done");

    // Masked channel stays pending until unmasked.
    write_mask(8'hFB);
    pulse_irq(2);
    repeat (6) cycle();
    check("s3_pend", 32'(pending_q), 32'h04);
    check("s3_noreq", 32'(irq_req), 32'd0);
    write_mask(8'hFF);
    check("s3_nextclk", 32'(irq_req), 32'd0);
    cycle();
    check("s3_req", 32'(irq_req), 32'd1);
    check("s3_vec", 32'(irq_vec), 32'd2);
    do_ack();
    do_eoi();
    $display("scenario mask done");

    // Trap preempting an in-service IRQ.
    pulse_irq(1);
    wait_req("s4i");
    check("s4_vec1", 32'(irq_vec), 32'd1);
    do_ack();
    check("s4_svc", 32'(in_service), 32'd1);
    trap_in = 1'b1;
    repeat (2) cycle();
    trap_in = 1'b0;
    wait_req("s4t");
    check("s4_tvec", 32'(irq_vec), 32'(N));
    check("s4_svc_off", 32'(in_service), 32'd0);
    do_ack();
    check("s4_trap", 32'(in_trap), 32'd1);
    do_eoi();
    check("s4_ret", 32'({in_service, in_trap}), 32'b10);
    do_eoi();
    check("s4_idle", 32'({in_service, in_trap}), 32'b00);
    $display("scenario trap_preempt done");

    // Level channel 0 held high re-requests after service.
    irq_in[0] = 1'b1;
    wait_req("s5a");
    check("s5_vec0", 32'(irq_vec), 32'd0);
    do_ack();
    do_eoi();
    cycle();
    check("s5_rereq", 32'(irq_req), 32'd1);
    check("s5_revec", 32'(irq_vec), 32'd0);
    irq_in[0] = 1'b0;
    repeat (5) cycle();
    do_ack();
    do_eoi();
    repeat (10) cycle();
    check("s5_quiet", 32'(irq_req), 32'd0);
    $display("scenario level done");

    // Reset asserted in the middle of a request.
    write_mask(8'h7F);
    pulse_irq(4);
    wait_req("s6");
    #2 reset_n = 1'b0;
    #1;
    check("s6_req", 32'(irq_req), 32'd0);
    check("s6_svc", 32'(in_service), 32'd0);
    check("s6_pend", 32'(pending_q), 32'd0);
    check("s6_mask", 32'(mask_q), 32'(MR));
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) begin
      cycle();
      check("s6_quiet", 32'(irq_req), 32'd0);
    end
    $display("scenario reset_mid done");

    // Random traffic, including spurious and simultaneous ack/eoi.
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(39) == 0) irq_in[i] = ~irq_in[i];
      if ($urandom_range(59) == 0) trap_in = ~trap_in;
      irq_ack    = irq_req ? ($urandom_range(3) == 0) : ($urandom_range(15) == 0);
      eoi        = (in_service || in_trap) ? ($urandom_range(5) == 0)
                                           : ($urandom_range(15) == 0);
      mask_we    = ($urandom_range(49) == 0);
      mask_wdata = N'($urandom);
      cycle();
    end
    irq_ack = 1'b0;
    eoi     = 1'b0;
    mask_we = 1'b0;
    $display("scenario random done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
- Parametrised interrupt/trap controller between external `intr`/`trap` sources and the CPU core.
- Successor to the single-line `intr`/`trap` inputs of `computer`.
- Synchronises N_IRQ maskable channels (per-channel edge or level mode) plus one non-maskable trap, and latches pending bits.
- Arbitrates by fixed priority and hands a vector to the CPU over a request/acknowledge/end-of-interrupt handshake; a trap may preempt one in-service maskable IRQ.

Parameters:
- N_IRQ, 8: number of maskable channels (1..16).
- VEC_W, $clog2(N_IRQ+1): vector width. Vector N_IRQ is reserved for trap.
- EDGE_MODE, {N_IRQ{1'b1}}: per-channel mode; bit=1 rising-edge, bit=0 level.
- SYNC_STAGES, 2: synchroniser depth (>=2).
- MASK_RST, {N_IRQ{1'b1}}: reset value of the mask register.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- irq_in  in  N_IRQ  raw interrupt lines, asynchronous to clk.
- trap_in  in  1  raw fault line, rising-edge, non-maskable.
- mask_we  in  1  write strobe for mask.
- mask_wdata  in  N_IRQ  new mask value; 1 = enabled.
- mask_q  out  N_IRQ  current mask.
- pending_q  out  N_IRQ  current pending bits (unmasked view).
- irq_req  out  1  request to CPU.
- irq_vec  out  VEC_W  vector; stable while irq_req=1.
- irq_ack  in  1  CPU accepts request; 1-cycle pulse.
- eoi  in  1  CPU end-of-interrupt (reti); 1-cycle pulse.
- in_service  out  1  a maskable IRQ is being serviced.
- in_trap  out  1  the trap handler is active.

Behaviour:
- Reset (async, reset_n=0): all sync flops, pending, trap_pend = 0; mask_q = MASK_RST; state=IDLE; irq_req=0, irq_vec=0, in_service=0, in_trap=0. Reset mid-handshake abandons it; no request after release until new source activity.
- Sync/detect: per line, SYNC_STAGES flops then a delay flop.
  - Edge mode: a pending bit is set the clock after the synced rise.
  - Level mode: pending loads the synced level every clock.
  - Trap: always edge-detected into trap_pend.
- Latency: irq_req rises SYNC_STAGES+2 clocks after the first clk edge that samples the source high (4 for default).
- Arbitration (IDLE or SVC only):
  - trap_pend beats all maskable channels.
  - Otherwise the lowest index of pending & mask_q wins.
  - Winner vector is registered into irq_vec on entering a REQ state.
- States:
  - IDLE:
    - trap_pend -> TREQ (from IDLE).
    - Any pending&mask -> REQ.
  - REQ:
    - irq_req=1.
    - irq_ack -> SVC: clears the winner's pending bit if edge mode; level bits are never cleared by ack.
    - Mask changes and trap arrival do not alter irq_vec while in REQ.
  - SVC:
    - in_service=1.
    - eoi -> IDLE.
    - trap_pend -> TREQ (preempt, return target SVC).
    - Maskable IRQs are not nested.
  - TREQ:
    - irq_req=1, irq_vec=N_IRQ.
    - irq_ack clears trap_pend -> TSVC.
  - TSVC:
    - in_trap=1.
    - eoi returns to the recorded return target (IDLE or SVC); in_service is restored if SVC.
- Handshake rules:
  - irq_ack outside REQ/TREQ is ignored.
  - eoi outside SVC/TSVC is ignored.
  - irq_ack and eoi in the same cycle: only the one valid for the current state acts.
- Simultaneous set/clear: a new edge on the channel being acked in the same cycle leaves pending=1 (set wins).
- Trap during TSVC: trap_pend is re-latched and served after eoi (one nesting level only).
- Mask: mask_we updates mask_q at the next edge. Pending bits are captured regardless of mask and request once unmasked.
- After eoi to IDLE, the next request is issued one clock later.

Decomposition:
- Package intr_pkg:
  - state enum {IDLE, REQ, SVC, TREQ, TSVC}.
  - Function trap_vec(N_IRQ).
  - Priority-encode function returning {valid, index}.
- Sub-module intr_sync_edge (params SYNC_STAGES, EDGE):
  - Async-reset synchroniser plus edge/level output.
  - Instantiated N_IRQ+1 times via generate.

Test Plan:
- Reset, single irq_in[3] pulse of 20 ns, no ack for 10 clocks -> irq_req=1 at clock 4 after sample, irq_vec=3, held stable. Then ack -> pending_q[3]=0, in_service=1. Then eoi -> in_service=0, irq_req stays 0.
- irq_in[5] and irq_in[2] rise in the same clock -> vec 2 first; after ack+eoi, vec 5 requested one clock after return to IDLE.
- mask_wdata=8'hFB (mask ch2), pulse irq_in[2] -> pending_q=8'h04, irq_req=0. Write 8'hFF -> irq_req=1 next-but-one clock, vec 2.
- In SVC for vec 1, pulse trap_in -> irq_req=1 with vec 8 (N_IRQ), in_service=0. Ack -> in_trap=1. eoi -> in_service=1, in_trap=0. eoi -> IDLE.
- Level channel (EDGE_MODE[0]=0), hold irq_in[0] high through ack+eoi -> re-requested vec 0. Drop the line -> no further request.
- Assert reset_n=0 while in REQ -> irq_req, in_service, pending_q go 0 immediately and mask_q=MASK_RST. After release with quiet inputs, irq_req stays 0 for 20 clocks.
